// File: rtl/image_serializer.sv
// Snapshots a packed binarized image on start and streams it out LSB byte first
// over a valid/ready handshake; byte k is img_in[k*BYTE_W +: BYTE_W].
module image_serializer #(
  parameter int unsigned TOTAL_BITS = 904,
  parameter int unsigned BYTE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TOTAL_BITS-1:0] img_in,
  output logic [BYTE_W-1:0]     data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  last,
  output logic [9:0]            read_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NUM_BYTES = (TOTAL_BITS + BYTE_W - 1) / BYTE_W;
  localparam int unsigned PAD_W     = NUM_BYTES * BYTE_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [6:0]            idx_q, idx_d;
  logic [TOTAL_BITS-1:0] snap_q, snap_d;
  logic [PAD_W-1:0]      snap_pad;
  logic                  is_last_idx;

  assign is_last_idx = (idx_q == 7'(NUM_BYTES - 1));

  // Zero-extend so a partial final byte reads 0 above TOTAL_BITS-1.
  always_comb begin
    snap_pad                 = '0;
    snap_pad[TOTAL_BITS-1:0] = snap_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    if (abort) begin
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            snap_d  = img_in;
            idx_d   = '0;
            state_d = StSend;
          end
        end
        StSend: begin
          if (data_ready) begin
            if (is_last_idx) begin
              state_d = StDone;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 7'd1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  // Outputs decode purely from registers so async reset clears them at once.
  always_comb begin
    data_valid = (state_q == StSend);
    busy       = (state_q == StSend);
    done       = (state_q == StDone);
    last       = data_valid && is_last_idx;
    read_addr  = 10'(idx_q) * 10'(BYTE_W);
    data_out   = data_valid ? snap_pad[idx_q*BYTE_W +: BYTE_W] : '0;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (rst)
    (state_q == StSend) |-> (idx_q < 7'(NUM_BYTES)));
  assert property (@(posedge clk) disable iff (rst)
    (state_q != StSend) |-> !data_valid);
`endif

endmodule
